config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/cfg_pkg.sv | 18 +
 rtl/cfg_serdes.sv | 101 ++++++++++
 rtl/config_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration loader: FSM encoding and default chain geometry.
// Pure declarations; no logic, no latency.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int CHAIN_LEN_DEF = 68;
  localparam int WORD_W_DEF    = 8;

  function automatic int num_words(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_serdes.sv
// Word-to-bit serialiser driving the CLB chain plus readback assembler packing chain_out LSB first.
// One registered bit per enabled cycle; stalls (prog_en low) whenever shifter and buffer are both empty.
module cfg_serdes
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              run,
  input  logic              buf_full,
  input  logic [WORD_W-1:0] buf_dat,
  input  logic              chain_out,
  output logic              take,
  output logic              fin,
  output logic              cfg_prog_in,
  output logic              cfg_prog_en,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int SH_W  = $clog2(WORD_W + 1);

  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W:0]    issued;
  logic [WORD_W-1:0] sh_dat;
  logic [SH_W-1:0]   sh_cnt;
  logic [WORD_W-1:0] rb_acc;
  logic [WORD_W-1:0] rb_word;
  logic [SH_W-1:0]   rb_idx;
  logic              more;
  logic              word_full;

  // Bits already placed on the chain, counting the one presented this cycle.
  assign issued    = {1'b0, bit_cnt} + {{CNT_W{1'b0}}, cfg_prog_en};
  assign more      = issued < (CNT_W + 1)'(CHAIN_LEN);
  assign take      = run && more && (sh_cnt == '0) && buf_full;
  assign fin       = run && cfg_prog_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign word_full = (rb_idx == SH_W'(WORD_W - 1));
  assign rb_word   = rb_acc | (WORD_W'(chain_out) << rb_idx);

  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      bit_cnt     <= '0;
      sh_dat      <= '0;
      sh_cnt      <= '0;
      rb_acc      <= '0;
      rb_idx      <= '0;
      rb_data     <= '0;
      rb_valid    <= 1'b0;
      cfg_prog_in <= 1'b0;
      cfg_prog_en <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clr) begin
        bit_cnt     <= '0;
        sh_dat      <= '0;
        sh_cnt      <= '0;
        rb_acc      <= '0;
        rb_idx      <= '0;
        cfg_prog_in <= 1'b0;
        cfg_prog_en <= 1'b0;
      end else if (!run) begin
        sh_cnt      <= '0;
        cfg_prog_in <= 1'b0;
        cfg_prog_en <= 1'b0;
      end else begin
        // The closing edge of an enabled cycle completes that shift and samples the chain tail.
        if (cfg_prog_en) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (word_full || fin) begin
            rb_data  <= rb_word;
            rb_valid <= 1'b1;
            rb_acc   <= '0;
            rb_idx   <= '0;
          end else begin
            rb_acc <= rb_word;
            rb_idx <= rb_idx + 1'b1;
          end
        end
        if (take) begin
          cfg_prog_in <= buf_dat[0];
          sh_dat      <= buf_dat >> 1;
          sh_cnt      <= SH_W'(WORD_W - 1);
          cfg_prog_en <= 1'b1;
        end else if (more && (sh_cnt != '0)) begin
          cfg_prog_in <= sh_dat[0];
          sh_dat      <= sh_dat >> 1;
          sh_cnt      <= sh_cnt - 1'b1;
          cfg_prog_en <= 1'b1;
        end else begin
          cfg_prog_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// Loads CHAIN_LEN configuration bits into the CLB chain from WORD_W words, reading the old contents back.
// One-word buffer refills the shifter with no gap; wr_ready low outside SHIFT, when buffer full, or after the final word.
module config_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              cfg_prog_in,
  output logic              cfg_prog_en,
  input  logic              chain_out,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int NWORDS = num_words(CHAIN_LEN, WORD_W);
  localparam int WC_W   = $clog2(NWORDS + 1);

  state_t            state;
  logic              buf_full;
  logic [WORD_W-1:0] buf_dat;
  logic [WC_W-1:0]   wcnt;
  logic              clr;
  logic              run;
  logic              accept;
  logic              take;
  logic              fin;

  assign clr      = (state == ST_IDLE) && start && !abort;
  assign run      = (state == ST_SHIFT) && !abort;
  assign wr_ready = (state == ST_SHIFT) && !buf_full && (wcnt < WC_W'(NWORDS));
  assign accept   = wr_valid && wr_ready && !abort;

  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      buf_full <= 1'b0;
      buf_dat  <= '0;
      wcnt     <= '0;
    end else if (abort) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      buf_full <= 1'b0;
    end else begin
      // Buffer fill and drain are mutually exclusive: accept needs it empty, take needs it full.
      if (accept) begin
        buf_full <= 1'b1;
        buf_dat  <= wr_data;
        wcnt     <= wcnt + 1'b1;
      end else if (take) begin
        buf_full <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= ST_SHIFT;
            busy     <= 1'b1;
            wcnt     <= '0;
            buf_full <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (fin) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          done     <= 1'b0;
          buf_full <= 1'b0;
        end
      endcase
    end
  end

  cfg_serdes #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W)
  ) u_serdes (
    .prog_clk   (prog_clk),
    .rst        (rst),
    .clr        (clr),
    .run        (run),
    .buf_full   (buf_full),
    .buf_dat    (buf_dat),
    .chain_out  (chain_out),
    .take       (take),
    .fin        (fin),
    .cfg_prog_in(cfg_prog_in),
    .cfg_prog_en(cfg_prog_en),
    .rb_data    (rb_data),
    .rb_valid   (rb_valid)
  );

endmodule
